// File: rtl/fuzz_vector_driver_pkg.sv
// Shared definitions for the fuzz vector driver: FSM encoding, LFSR taps,
// CRC polynomial, seed-mix constant and the single-step helpers.
package fuzz_vector_driver_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int LFSR_W   = 96;
  localparam int LFSR_TAP0 = 95;
  localparam int LFSR_TAP1 = 93;
  localparam int LFSR_TAP2 = 48;
  localparam int LFSR_TAP3 = 46;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED_MIX = 32'hA5A5A5A5;

  // Fibonacci shift-left; the feedback bit enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_TAP0] ^ v[LFSR_TAP1] ^ v[LFSR_TAP2] ^ v[LFSR_TAP3]};
  endfunction

  function automatic logic [31:0] crc32_step(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? CRC_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/fuzz_misr32.sv
// 32-bit MISR compacting a 96-bit response, folded into three 32-bit words.
module fuzz_misr32
  import fuzz_vector_driver_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [95:0] data,
  output logic [31:0] signature
);

  logic [31:0] sig_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 32'h0;
    end else if (clear) begin
      sig_q <= 32'hFFFF_FFFF;
    end else if (enable) begin
      sig_q <= crc32_step(sig_q) ^ (data[95:64] ^ data[63:32] ^ data[31:0]);
    end
  end

  assign signature = sig_q;

endmodule

// File: rtl/fuzz_vector_driver.sv
// Drives LFSR stimulus into a DUT of fixed LATENCY and compacts the
// responses into a MISR signature, one run per accepted start.
module fuzz_vector_driver
  import fuzz_vector_driver_pkg::*;
#(
  parameter int LATENCY = 0,
  parameter int SIG_W   = 32
) (
  input  logic             clkin_data,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [15:0]      num_vectors,
  output logic [95:0]      dut_in,
  input  logic [95:0]      dut_out,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      vec_count
);

  logic [1:0]  state_q, state_d;
  logic [95:0] lfsr_q, lfsr_d;
  logic [15:0] vec_cnt_q, vec_cnt_d;
  logic [15:0] nv_q, nv_d;
  logic [15:0] drain_q, drain_d;
  logic        misr_clear;
  logic        drive;
  logic        sample_en;

  assign drive = (state_q == ST_DRIVE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    vec_cnt_d  = vec_cnt_q;
    nv_d       = nv_q;
    drain_d    = drain_q;
    misr_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lfsr_d     = {~seed, seed, seed ^ SEED_MIX};
          vec_cnt_d  = 16'd0;
          nv_d       = num_vectors;
          misr_clear = 1'b1;
          state_d    = (num_vectors == 16'd0) ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        lfsr_d    = lfsr_step(lfsr_q);
        vec_cnt_d = vec_cnt_q + 16'd1;
        // nv_q is non-zero here, so nv_q - 1 cannot wrap.
        if (vec_cnt_q == nv_q - 16'd1) begin
          drain_d = 16'd0;
          state_d = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 16'(LATENCY - 1)) state_d = ST_DONE;
        else                             drain_d = drain_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin_data or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= '0;
      vec_cnt_q <= '0;
      nv_q      <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      vec_cnt_q <= vec_cnt_d;
      nv_q      <= nv_d;
      drain_q   <= drain_d;
    end
  end

  // Each applied vector is tagged; its response is sampled when the tag
  // reaches the end of a pipe as deep as the DUT.
  generate
    if (LATENCY == 0) begin : g_comb_dut
      assign sample_en = drive;
    end else begin : g_seq_dut
      logic [LATENCY-1:0] vpipe_q;
      always_ff @(posedge clkin_data or negedge rst_n) begin
        if (!rst_n) vpipe_q <= '0;
        else        vpipe_q <= (vpipe_q << 1) | LATENCY'(drive);
      end
      assign sample_en = vpipe_q[LATENCY-1];
    end
  endgenerate

  fuzz_misr32 u_misr (
    .clk       (clkin_data),
    .rst_n     (rst_n),
    .clear     (misr_clear),
    .enable    (sample_en),
    .data      (dut_out),
    .signature (signature)
  );

  assign dut_in    = lfsr_q;
  assign vec_count = vec_cnt_q;
  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_fuzz_vector_driver.sv
// Randomised bench for fuzz_vector_driver: a combinational-DUT instance and a
// two-stage-DUT instance, checked against a behavioural stimulus/MISR model.
module tb_fuzz_vector_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_r;
  logic        sel;
  logic [31:0] seed_r;
  logic [15:0] num_r;

  logic [95:0] dut_in0, dut_out0, dut_in2, dut_out2;
  logic        busy0, done0, busy2, done2;
  logic [31:0] sig0, sig2;
  logic [15:0] vc0, vc2;
  logic [95:0] d1_q, d2_q;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fuzz_vector_driver #(.LATENCY(0)) dut0 (
    .clkin_data (clk),       .rst_n (rst_n),
    .start      (start_r && !sel),
    .seed       (seed_r),    .num_vectors (num_r),
    .dut_in     (dut_in0),   .dut_out (dut_out0),
    .busy       (busy0),     .done (done0),
    .signature  (sig0),      .vec_count (vc0)
  );

  fuzz_vector_driver #(.LATENCY(2)) dut2 (
    .clkin_data (clk),       .rst_n (rst_n),
    .start      (start_r && sel),
    .seed       (seed_r),    .num_vectors (num_r),
    .dut_in     (dut_in2),   .dut_out (dut_out2),
    .busy       (busy2),     .done (done2),
    .signature  (sig2),      .vec_count (vc2)
  );

  // Stand-in DUTs: a combinational scramble, and a plain two-cycle delay.
  function automatic logic [95:0] resp0(input logic [95:0] v);
    return {v[63:0], v[95:64]} ^ 96'h0123456789ABCDEF_FEDCBA98;
  endfunction

  assign dut_out0 = resp0(dut_in0);
  assign dut_out2 = d2_q;

  always @(posedge clk) begin
    d1_q <= dut_in2;
    d2_q <= d1_q;
  end

  // Reference model: next LFSR state and one MISR absorption, as arithmetic.
  function automatic logic [95:0] model_next(input logic [95:0] v);
    logic fb;
    fb = v[95] ^ v[93] ^ v[48] ^ v[46];
    return (v << 1) | {95'd0, fb};
  endfunction

  function automatic logic [31:0] model_absorb(input logic [31:0] s, input logic [95:0] r);
    logic [31:0] shifted;
    shifted = s << 1;
    if (s[31]) shifted = shifted ^ 32'h04C11DB7;
    return shifted ^ r[31:0] ^ r[63:32] ^ r[95:64];
  endfunction

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One complete run on the selected instance, every cycle compared to the model.
  task automatic run(input logic which, input logic [31:0] s, input logic [15:0] n,
                     input logic pulse_mid);
    int          lat, i, k, busy_cnt, exp_done_at;
    logic        seen;
    logic [95:0] exp_vec;
    logic [31:0] exp_sig;
    lat         = which ? 2 : 0;
    exp_done_at = (n == 16'd0) ? 0 : int'(n) + lat;
    exp_vec     = {~s, s, s ^ 32'hA5A5A5A5};
    exp_sig     = 32'hFFFF_FFFF;
    sel         = which;
    start_r = 1'b1; seed_r = s; num_r = n;
    @(negedge clk);
    start_r = 1'b0; seed_r = $urandom; num_r = 16'($urandom);
    i = 0; k = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && i <= int'(n) + lat + 8) begin
      if (which ? busy2 : busy0) begin
        busy_cnt++;
        if (k < int'(n)) begin
          if (k < 64) check("dut_in", which ? dut_in2 : dut_in0, exp_vec);
          exp_sig = model_absorb(exp_sig, which ? exp_vec : resp0(exp_vec));
          exp_vec = model_next(exp_vec);
          k++;
        end
      end
      if (which ? done2 : done0) begin
        seen = 1'b1;
        check("done_cycle", 96'(i), 96'(exp_done_at));
      end else begin
        start_r = pulse_mid && (i == 1);
        if (pulse_mid && i == 1) begin seed_r = $urandom; num_r = 16'($urandom); end
        @(negedge clk);
        i++;
      end
    end
    start_r = 1'b0;
    check("done_seen", 96'(seen), 96'd1);
    check("busy_cycles", 96'(busy_cnt), 96'(exp_done_at));
    check("signature", which ? sig2 : sig0, exp_sig);
    check("vec_count", which ? vc2 : vc0, n);
    @(negedge clk);
    check("done_pulse_end", which ? done2 : done0, 1'b0);
    check("signature_hold", which ? sig2 : sig0, exp_sig);
  endtask

  initial begin
    rst_n = 1'b0; start_r = 1'b0; sel = 1'b0; seed_r = '0; num_r = '0;
    repeat (2) @(negedge clk);
    check("rst_dut_in0", dut_in0, 96'd0);
    check("rst_sig0", sig0, 32'd0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_vc0", vc0, 16'd0);
    check("rst_dut_in2", dut_in2, 96'd0);
    check("rst_sig2", sig2, 32'd0);
    check("rst_busy2", busy2, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 32'h0, 16'd1, 1'b0);
    run(1'b0, $urandom, 16'd0, 1'b0);
    run(1'b1, $urandom, 16'd4, 1'b0);
    begin
      logic [31:0] s;
      s = $urandom;
      run(1'b0, s, 16'd6, 1'b1);
      run(1'b0, s, 16'd6, 1'b0);
      run(1'b1, s, 16'd5, 1'b1);
    end
    for (int r = 0; r < 6; r++) begin
      run(1'b0, $urandom, 16'($urandom_range(1, 20)), 1'b0);
      run(1'b1, $urandom, 16'($urandom_range(1, 20)), 1'b0);
    end

    // Asynchronous reset in the middle of a run.
    sel = 1'b0;
    start_r = 1'b1; seed_r = $urandom; num_r = 16'd10;
    @(negedge clk);
    start_r = 1'b0;
    for (int w = 0; w < 20 && vc0 != 16'd3; w++) @(negedge clk);
    check("rst_mid_vc_reached", vc0, 16'd3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_dut_in", dut_in0, 96'd0);
    check("rst_mid_sig", sig0, 32'd0);
    check("rst_mid_vc", vc0, 16'd0);
    check("rst_mid_busy", busy0, 1'b0);
    check("rst_mid_done", done0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < 12; w++) begin
      @(negedge clk);
      check("no_done_after_rst", {busy0, done0}, 2'b00);
    end
    run(1'b0, $urandom, 16'd7, 1'b0);

    run(1'b0, $urandom, 16'hFFFF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
